layer_scroll_ctrl: RTL and testbench

LAYER_SCROLL_CTRL -- requirements
Module: layer_scroll_ctrl

---
 rtl/layer_scroll_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_layer_scroll_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scroll_ctrl.sv
// layer_scroll_ctrl: per-frame scroll offset sequencer for up to four layers.
// Each vsync rising edge triggers one pass over the layers, with one layer per
// clock and layer 0 first. For each layer and axis the pass either applies a
// pending offset load or steps the offset by its velocity, wrapping at +/-LIMIT.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   vsync                 async frame strobe (rising edge = frame start)
//   run                   1: apply velocities each frame, 0: hold offsets
//   cfg_valid/cfg_ready   config write handshake (ready only while IDLE)
//   cfg_layer/sel/data    target layer, register select, signed write data
//   hoffset/voffset       packed signed offsets, layer k at [k*OFS_W +: OFS_W]
//   frame_tick            one-cycle pulse after the last layer is updated
//   overrun               sticky: a frame edge arrived while busy

// One axis (h or v) of one layer: offset, velocity and the pending load.
module layer_scroll_axis #(
  parameter int OFS_W    = 12,
  parameter int LIMIT    = 600,
  parameter int OFS_INIT = 0,
  parameter int VEL_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vel_i,
  input  logic             wr_ld_i,
  input  logic [OFS_W-1:0] data_i,
  input  logic             upd_i,
  input  logic             run_i,
  output logic [OFS_W-1:0] ofs_o
);
  localparam int W1 = OFS_W + 1;
  localparam logic signed [OFS_W:0]   LIM_P  = W1'(LIMIT);
  localparam logic signed [OFS_W:0]   LIM_N  = W1'(-LIMIT);
  localparam logic signed [OFS_W-1:0] LIM_PW = OFS_W'(LIMIT);
  localparam logic signed [OFS_W-1:0] LIM_NW = OFS_W'(-LIMIT);
  localparam logic signed [OFS_W-1:0] OFS_RST = OFS_W'(OFS_INIT);
  localparam logic signed [OFS_W-1:0] VEL_RST = OFS_W'(VEL_INIT);

  logic signed [OFS_W-1:0] ofs_q, ofs_d, vel_q, vel_d, ld_q, ld_d;
  logic                    pend_q, pend_d;
  logic signed [OFS_W:0]   sum, ld_x;
  logic signed [OFS_W-1:0] step_v, load_v;

  always_comb begin
    // One extra bit so the sum never overflows before the wrap test.
    sum  = $signed({ofs_q[OFS_W-1], ofs_q}) + $signed({vel_q[OFS_W-1], vel_q});
    ld_x = $signed({ld_q[OFS_W-1], ld_q});
    // Wrap: falling off one end re-enters at the opposite end.
    if (sum < LIM_N)      step_v = LIM_PW;
    else if (sum > LIM_P) step_v = LIM_NW;
    else                  step_v = sum[OFS_W-1:0];
    // Loaded values are clamped, not wrapped.
    if (ld_x > LIM_P)      load_v = LIM_PW;
    else if (ld_x < LIM_N) load_v = LIM_NW;
    else                   load_v = ld_q;

    ofs_d  = ofs_q;
    vel_d  = vel_q;
    ld_d   = ld_q;
    pend_d = pend_q;
    if (upd_i) begin
      if (pend_q) begin
        ofs_d  = load_v;
        pend_d = 1'b0;
      end else if (run_i) begin
        ofs_d = step_v;
      end
    end
    if (wr_vel_i) vel_d = $signed(data_i);
    if (wr_ld_i) begin
      ld_d   = $signed(data_i);
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofs_q  <= OFS_RST;
      vel_q  <= VEL_RST;
      ld_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      ofs_q  <= ofs_d;
      vel_q  <= vel_d;
      ld_q   <= ld_d;
      pend_q <= pend_d;
    end
  end

  assign ofs_o = ofs_q;
endmodule

module layer_scroll_ctrl #(
  parameter int NUM_LAYERS = 2,
  parameter int OFS_W      = 12,
  parameter int LIMIT      = 600,
  parameter int H_INIT     = 600,
  parameter int H_VEL_INIT = -20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vsync,
  input  logic                        run,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [1:0]                  cfg_layer,
  input  logic [1:0]                  cfg_sel,
  input  logic [OFS_W-1:0]            cfg_data,
  output logic [NUM_LAYERS*OFS_W-1:0] hoffset,
  output logic [NUM_LAYERS*OFS_W-1:0] voffset,
  output logic                        frame_tick,
  output logic                        overrun
);
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
  localparam logic [1:0] LAST = 2'(NUM_LAYERS - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       sync1_q, sync2_q, sync3_q;
  logic [2:0] vld_pipe_q;   // marks which sync flops hold a real post-reset sample
  logic       fedge_q, overrun_d, overrun_q;
  logic       frame_edge, wr;

  // The valid pipe stops a vsync that is already high at reset release from
  // counting as an edge: sync3 must hold a genuine low sample first.
  assign frame_edge = sync2_q & ~sync3_q & vld_pipe_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      vld_pipe_q <= '0;
      fedge_q    <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= vsync;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
      fedge_q    <= frame_edge;
      state_q    <= state_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cfg_ready  = 1'b0;
    frame_tick = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        idx_d     = '0;
        if (fedge_q) state_d = UPDATE;
      end
      UPDATE: begin
        overrun_d = overrun_q | fedge_q;
        idx_d     = idx_q + 2'd1;
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        overrun_d  = overrun_q | fedge_q;
        frame_tick = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun = overrun_q;
  assign wr      = cfg_valid & cfg_ready;

  // Writes to layers >= NUM_LAYERS match no instance and are silently dropped.
  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    logic hit, upd;
    assign hit = wr & (cfg_layer == 2'(k));
    assign upd = (state_q == UPDATE) & (idx_q == 2'(k));

    layer_scroll_axis #(.OFS_W(OFS_W), .LIMIT(LIMIT), .OFS_INIT(H_INIT), .VEL_INIT(H_VEL_INIT)) u_h (
      .clk(clk), .rst_n(rst_n),
      .wr_vel_i(hit & (cfg_sel == 2'b00)), .wr_ld_i(hit & (cfg_sel == 2'b10)),
      .data_i(cfg_data), .upd_i(upd), .run_i(run),
      .ofs_o(hoffset[k*OFS_W +: OFS_W])
    );

    layer_scroll_axis #(.OFS_W(OFS_W), .LIMIT(LIMIT), .OFS_INIT(0), .VEL_INIT(0)) u_v (
      .clk(clk), .rst_n(rst_n),
      .wr_vel_i(hit & (cfg_sel == 2'b01)), .wr_ld_i(hit & (cfg_sel == 2'b11)),
      .data_i(cfg_data), .upd_i(upd), .run_i(run),
      .ofs_o(voffset[k*OFS_W +: OFS_W])
    );
  end
endmodule

// File: tb/tb_layer_scroll_ctrl.sv
module tb_layer_scroll_ctrl;
  localparam int NL = 2;
  localparam int W  = 12;

  logic          clk = 1'b0;
  logic          rst_n, vsync, run, cfg_valid, cfg_ready, frame_tick, overrun;
  logic [1:0]    cfg_layer, cfg_sel;
  logic [W-1:0]  cfg_data;
  logic [NL*W-1:0] hoffset, voffset;

  layer_scroll_ctrl #(.NUM_LAYERS(NL), .OFS_W(W), .LIMIT(600), .H_INIT(600), .H_VEL_INIT(-20)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .hoffset(hoffset), .voffset(voffset),
    .frame_tick(frame_tick), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         wr;
    logic [1:0] lay;
    logic [1:0] sel;
    int         data;
    bit         run;
    bit         frm;
    int         h0, h1, v0, v1;
  } vec_t;
  vec_t tbl[16];

  logic signed [31:0] h0_at[16], h1_at[16];
  logic               rdy_at[16], ovr_at[16];
  int                 tick_cnt, tick_j;

  function automatic logic signed [31:0] hof(input int k);
    hof = $signed(hoffset[k*W +: W]);
  endfunction
  function automatic logic signed [31:0] vof(input int k);
    vof = $signed(voffset[k*W +: W]);
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input int h0, input int h1, input int v0, input int v1);
    chk({nm, ".h0"}, hof(0), h0);
    chk({nm, ".h1"}, hof(1), h1);
    chk({nm, ".v0"}, vof(0), v0);
    chk({nm, ".v1"}, vof(1), v1);
  endtask

  // One vsync pulse; j indexes negedges after the first edge that samples it high.
  task automatic do_frame();
    tick_cnt = 0;
    tick_j   = -1;
    @(negedge clk);
    vsync = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 2) vsync = 1'b0;
      h0_at[j]  = hof(0);
      h1_at[j]  = hof(1);
      rdy_at[j] = cfg_ready;
      ovr_at[j] = overrun;
      if (frame_tick) begin
        tick_cnt++;
        tick_j = j;
      end
    end
  endtask

  task automatic cfg_wr(input logic [1:0] l, input logic [1:0] s, input int d);
    int n;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_layer = l;
    cfg_sel   = s;
    cfg_data  = W'(d);
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wr_accept", cfg_ready, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_j;
    rst_n = 1'b0; vsync = 1'b0; run = 1'b1; cfg_valid = 1'b0;
    cfg_layer = '0; cfg_sel = '0; cfg_data = '0;

    tbl[0]  = '{0, 2'd0, 2'd0, 0,     1, 1,  560,  560,    0,   0};
    tbl[1]  = '{0, 2'd0, 2'd0, 0,     1, 1,  540,  540,    0,   0};
    tbl[2]  = '{1, 2'd1, 2'd1, 7,     1, 0,  540,  540,    0,   0};
    tbl[3]  = '{1, 2'd0, 2'd2, -5,    1, 1,   -5,  520,    0,   7};
    tbl[4]  = '{0, 2'd0, 2'd0, 0,     1, 1,  -25,  500,    0,  14};
    tbl[5]  = '{1, 2'd1, 2'd3, 100,   1, 0,  -25,  500,    0,  14};
    tbl[6]  = '{1, 2'd1, 2'd3, 200,   1, 1,  -45,  480,    0, 200};
    tbl[7]  = '{1, 2'd0, 2'd3, 1000,  1, 1,  -65,  460,  600, 207};
    tbl[8]  = '{1, 2'd0, 2'd0, 50,    1, 0,  -65,  460,  600, 207};
    tbl[9]  = '{0, 2'd0, 2'd0, 0,     1, 1,  -15,  440,  600, 214};
    tbl[10] = '{1, 2'd0, 2'd2, -2000, 0, 1, -600,  440,  600, 214};
    tbl[11] = '{0, 2'd0, 2'd0, 0,     0, 1, -600,  440,  600, 214};
    tbl[12] = '{0, 2'd0, 2'd0, 0,     0, 1, -600,  440,  600, 214};
    tbl[13] = '{1, 2'd3, 2'd0, 99,    1, 1, -550,  420,  600, 221};
    tbl[14] = '{1, 2'd0, 2'd1, 1,     1, 1, -500,  400, -600, 228};
    tbl[15] = '{0, 2'd0, 2'd0, 0,     1, 1, -450,  380, -599, 235};

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    chk_outs("reset", 600, 600, 0, 0);
    chk("reset.tick", frame_tick, 0);
    chk("reset.ovr", overrun, 0);
    chk("reset.rdy", cfg_ready, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First frame: per-layer update timing, tick position, ready deassertion
    do_frame();
    chk("t.h0_pre", h0_at[3], 600);
    chk("t.h0_upd", h0_at[4], 580);
    chk("t.h1_pre", h1_at[4], 600);
    chk("t.h1_upd", h1_at[5], 580);
    chk("t.tick_cnt", tick_cnt, 1);
    chk("t.tick_j", tick_j, NL + 3);
    chk("t.rdy_idle", rdy_at[2], 1);
    chk("t.rdy_upd", rdy_at[3], 0);
    chk("t.rdy_done", rdy_at[5], 0);
    chk("t.rdy_back", rdy_at[6], 1);
    chk_outs("t.end", 580, 580, 0, 0);

    // Table of frame-level vectors
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) cfg_wr(tbl[i].lay, tbl[i].sel, tbl[i].data);
      run = tbl[i].run;
      if (tbl[i].frm) begin
        do_frame();
        chk($sformatf("v%0d.tick", i), tick_cnt, 1);
      end
      chk_outs($sformatf("v%0d", i), tbl[i].h0, tbl[i].h1, tbl[i].v0, tbl[i].v1);
    end
    run = 1'b1;

    // Write stalled across a frame, plus a second vsync edge during UPDATE
    acc_j = -1;
    tick_cnt = 0;
    @(negedge clk);
    vsync = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (j == 0) vsync = 1'b0;
      if (j == 1) vsync = 1'b1;
      if (j == 3) vsync = 1'b0;
      if (cfg_valid && acc_j >= 0) cfg_valid = 1'b0;
      else if (cfg_valid && cfg_ready) acc_j = j;
      if (j == 3) begin
        cfg_valid = 1'b1; cfg_layer = 2'd1; cfg_sel = 2'd2; cfg_data = W'(123);
      end
      rdy_at[j] = cfg_ready;
      ovr_at[j] = overrun;
      if (frame_tick) tick_cnt++;
    end
    chk("ov.rdy_upd", rdy_at[4], 0);
    chk("ov.rdy_done", rdy_at[5], 0);
    chk("ov.acc_j", acc_j, 6);
    chk("ov.ovr_pre", ovr_at[4], 0);
    chk("ov.ovr_set", ovr_at[5], 1);
    chk("ov.ticks", tick_cnt, 1);
    chk_outs("ov.frame", -400, 360, -598, 242);
    do_frame();
    chk_outs("ov.load", -350, 123, -597, 249);
    chk("ov.sticky", overrun, 1);

    // Reset in the layer-1 update cycle, released with vsync high
    @(negedge clk);
    vsync = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 2) vsync = 1'b0;
    end
    chk("rs.h0_mid", hof(0), -300);
    rst_n = 1'b0;
    vsync = 1'b1;
    #1;
    chk_outs("rs.async", 600, 600, 0, 0);
    chk("rs.tick", frame_tick, 0);
    chk("rs.ovr", overrun, 0);
    chk("rs.rdy", cfg_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (frame_tick) tick_cnt++;
    end
    chk("rs.no_frame", tick_cnt, 0);
    chk("rs.hold", hof(0), 600);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    do_frame();
    chk("rs.tick1", tick_cnt, 1);
    chk_outs("rs.frame", 580, 580, 0, 0);

    // Wrap at the negative bound from reset state
    do_reset();
    acc_j = 0;
    for (int f = 0; f < 60; f++) begin
      do_frame();
      acc_j += tick_cnt;
    end
    chk("wrap.ticks", acc_j, 60);
    chk_outs("wrap.60", -600, -600, 0, 0);
    do_frame();
    chk_outs("wrap.61", 600, 600, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
